inst_fetch_queue: RTL and testbench
===================================

Name: inst_fetch_queue

Overview:
- Parametrised successor to the single-entry fetch/decode register: owns the fetch PC, issues word-addressed reads to the synchronous instruction memory, and buffers pre-split instructions in a DEPTH-entry circular FIFO.
- Supplies decoded fields to the dispatch stage through a valid/ready handshake.
- Supports redirect (branch/jump/mispredict) flush and memory-bound checking.
- Sits between instruction memory and the issue/reservation-station logic of the out-of-order core.

Parameters:
- DEPTH, 8, queue entries; power of two, >= 2.
- MEM_BITS, 11, instruction memory address width in words.
- MEM_SIZE, 2048, number of valid instruction words; must be <= 2**MEM_BITS.
- RESET_PC, 0, fetch PC loaded on reset.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- redirect_valid  in  1  flush queue and restart fetch at redirect_pc.
- redirect_pc  in  32  new word-addressed fetch PC.
- imem_rd  out  1  fetch request this cycle.
- imem_addr  out  MEM_BITS  word address of request; equals fetch_pc[MEM_BITS-1:0].
- imem_rdata  in  32  instruction word, valid one cycle after imem_rd.
- deq_ready  in  1  consumer accepts head entry.
- deq_valid  out  1  head entry valid; equals !empty.
- opcode  out  12  {inst[31:26], inst[5:0]} if inst[31:26]==0, else {inst[31:26], 6'd0}.
- rs, rt, rd, shamt  out  5 each  inst[25:21], inst[20:16], inst[15:11], inst[10:6].
- immediate  out  16  inst[15:0].
- address  out  26  inst[25:0].
- pc  out  32  PC of head instruction.
- count  out  $clog2(DEPTH)+1  occupied entries.
- full  out  1  count==DEPTH.

Behaviour:
- Reset (rst_n low, asynchronous): fetch_pc=RESET_PC, rd/wr pointers=0, count=0, inflight=0, imem_rd=0, deq_valid=0; all head fields read as 0 (storage cleared).
- Fetch issue:
  - imem_rd = !redirect_valid && (fetch_pc < MEM_SIZE) && (count + inflight < DEPTH). The check is conservative: it ignores a same-cycle dequeue.
  - On issue, fetch_pc increments by 1 and inflight<=1 for the next cycle.
  - At most one request is outstanding.
- Response:
  - In the cycle after an issue, imem_rdata is split into fields and written at wr_ptr together with its PC, which is captured at issue in a pc_pipe register.
  - wr_ptr wraps modulo DEPTH.
- Latency: a request in cycle t appears as deq_valid in cycle t+2 if the queue was empty. Head fields are combinational from the head entry; there is no output register.
- Dequeue: fire = deq_valid && deq_ready && !redirect_valid. rd_ptr advances and wraps modulo DEPTH.
- Simultaneous write and fire: count unchanged. Writing when full cannot occur by construction; assert this in simulation.
- Redirect (single cycle, highest priority):
  - count, pointers and inflight are cleared.
  - Any response arriving this cycle is discarded.
  - No fetch is issued; no dequeue is accepted.
  - fetch_pc<=redirect_pc; fetching resumes in the next cycle.
- Out-of-range PC: when fetch_pc >= MEM_SIZE, fetch stalls (imem_rd=0). The queue drains normally, and only a redirect leaves this state.
- Redirect during reset has no effect; reset wins.

Optional Feature:
- Macro: IFQ_PREDECODE_EN.
- Defined:
  - Each entry stores two extra bits computed at write, exposed as outputs is_branch and is_jump.
  - is_branch=1 for opcode[11:6] in {6'h04, 6'h05}.
  - is_jump=1 for opcode[11:6] in {6'h02, 6'h03}, or for opcode==12'h008 (jr).
  - Both bits are 0 on reset and redirect.
- Not defined: the outputs and storage are absent; all other behaviour is identical.

Test Plan:
- Reset release, memory words 0..3 = 0x012A4020 (add), 0x8C080004, 0x10000002, 0x08000010; deq_ready=1. Required response:
  - imem_rd is high from cycle 0 with addr 0,1,2,3...
  - deq_valid first rises at cycle 2 with opcode=12'h020, rs=9, rt=10, rd=8, pc=0.
  - Then opcode=12'h8C0 with immediate=4, pc=1.
- deq_ready=0 throughout, DEPTH=8 -> count reaches 8; full=1; imem_rd stays low after 8 issues; fetch_pc=8; no entry is overwritten.
- Queue full, then deq_ready=1 for one cycle -> count=7. The next issue happens in the following cycle, and count returns to 8 two cycles later.
- With count=5 and a request in flight, pulse redirect_valid with redirect_pc=100 -> the next cycle has count=0, deq_valid=0 and imem_addr=100. The in-flight word is never enqueued. The first new entry has pc=100.
- redirect_pc=2046, MEM_SIZE=2048 -> exactly two fetches (2046, 2047), then imem_rd=0 indefinitely; the queue drains to empty and stays empty.
- Assert rst_n low mid-stream with count=4 -> deq_valid, count and imem_rd drop to 0 immediately (asynchronously). After release, fetch restarts at RESET_PC.

Source files
------------

// File: rtl/inst_fetch_queue.sv
// Instruction fetch queue: owns the fetch PC, issues word reads to the synchronous imem and buffers
// pre-split instructions in a DEPTH-entry circular FIFO. Define IFQ_PREDECODE_EN for is_branch/is_jump.
package inst_fetch_queue_pkg;

    typedef struct packed {
        logic [11:0] opcode;
        logic [25:0] body;
        logic [31:0] pc;
    } ifq_entry_t;

    // R-type instructions carry their function code in the low opcode bits.
    function automatic logic [11:0] split_opcode(input logic [31:0] inst);
        return (inst[31:26] == 6'd0) ? {inst[31:26], inst[5:0]} : {inst[31:26], 6'd0};
    endfunction

endpackage

module inst_fetch_queue
    import inst_fetch_queue_pkg::*;
#(
    parameter int unsigned DEPTH    = 8,
    parameter int unsigned MEM_BITS = 11,
    parameter int unsigned MEM_SIZE = 2048,
    parameter int unsigned RESET_PC = 0
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    redirect_valid,
    input  logic [31:0]             redirect_pc,
    output logic                    imem_rd,
    output logic [MEM_BITS-1:0]     imem_addr,
    input  logic [31:0]             imem_rdata,
    input  logic                    deq_ready,
    output logic                    deq_valid,
    output logic [11:0]             opcode,
    output logic [4:0]              rs,
    output logic [4:0]              rt,
    output logic [4:0]              rd,
    output logic [4:0]              shamt,
    output logic [15:0]             immediate,
    output logic [25:0]             address,
    output logic [31:0]             pc,
    output logic [$clog2(DEPTH):0]  count,
    output logic                    full
`ifdef IFQ_PREDECODE_EN
    ,
    output logic                    is_branch,
    output logic                    is_jump
`endif
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam int unsigned SUM_W = CNT_W + 1;

    logic [31:0]      fetch_pc_q, fetch_pc_d;
    logic [31:0]      pc_pipe_q, pc_pipe_d;
    logic             inflight_q, inflight_d;
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;

    ifq_entry_t       mem_q [DEPTH];
    ifq_entry_t       wr_entry;
    ifq_entry_t       head;

    logic             room;
    logic             issue;
    logic             wr_en;
    logic             fire;

    // Room check counts the outstanding response but deliberately ignores a same-cycle dequeue.
    assign room  = (SUM_W'(count_q) + SUM_W'(inflight_q)) < SUM_W'(DEPTH);
    assign issue = rst_n && !redirect_valid && (fetch_pc_q < 32'(MEM_SIZE)) && room;
    assign wr_en = inflight_q && !redirect_valid;
    assign fire  = deq_valid && deq_ready && !redirect_valid;

    assign wr_entry.opcode = split_opcode(imem_rdata);
    assign wr_entry.body   = imem_rdata[25:0];
    assign wr_entry.pc     = pc_pipe_q;

    // Next-state logic; redirect overrides everything else.
    always_comb begin
        fetch_pc_d = fetch_pc_q;
        pc_pipe_d  = pc_pipe_q;
        inflight_d = issue;
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;

        if (redirect_valid) begin
            fetch_pc_d = redirect_pc;
            wr_ptr_d   = '0;
            rd_ptr_d   = '0;
            count_d    = '0;
        end else begin
            if (issue) begin
                fetch_pc_d = fetch_pc_q + 32'd1;
                pc_pipe_d  = fetch_pc_q;
            end
            if (wr_en) begin
                wr_ptr_d = wr_ptr_q + PTR_W'(1);
            end
            if (fire) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            case ({wr_en, fire})
                2'b10:   count_d = count_q + CNT_W'(1);
                2'b01:   count_d = count_q - CNT_W'(1);
                default: count_d = count_q;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q <= 32'(RESET_PC);
            pc_pipe_q  <= '0;
            inflight_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            fetch_pc_q <= fetch_pc_d;
            pc_pipe_q  <= pc_pipe_d;
            inflight_q <= inflight_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Entry storage is cleared on reset so the head fields read as zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en) begin
            mem_q[wr_ptr_q] <= wr_entry;
        end
    end

`ifdef IFQ_PREDECODE_EN
    logic [1:0] pd_q [DEPTH];
    logic [1:0] pd_wr;
    logic [5:0] wr_op6;

    assign wr_op6   = imem_rdata[31:26];
    assign pd_wr[1] = (wr_op6 == 6'h04) || (wr_op6 == 6'h05);
    assign pd_wr[0] = (wr_op6 == 6'h02) || (wr_op6 == 6'h03) || (wr_entry.opcode == 12'h008);

    // Predecode bits are wiped on redirect as well as reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pd_q[i] <= 2'b00;
            end
        end else if (redirect_valid) begin
            for (int i = 0; i < int'(DEPTH); i++) begin
                pd_q[i] <= 2'b00;
            end
        end else if (wr_en) begin
            pd_q[wr_ptr_q] <= pd_wr;
        end
    end

    assign is_branch = pd_q[rd_ptr_q][1];
    assign is_jump   = pd_q[rd_ptr_q][0];
`endif

    assign head      = mem_q[rd_ptr_q];
    assign imem_rd   = issue;
    assign imem_addr = fetch_pc_q[MEM_BITS-1:0];
    assign deq_valid = (count_q != '0);
    assign count     = count_q;
    assign full      = (count_q == CNT_W'(DEPTH));
    assign opcode    = head.opcode;
    assign rs        = head.body[25:21];
    assign rt        = head.body[20:16];
    assign rd        = head.body[15:11];
    assign shamt     = head.body[10:6];
    assign immediate = head.body[15:0];
    assign address   = head.body;
    assign pc        = head.pc;

    // A response can never land in a full queue because issue reserves its slot.
    wr_never_full: assert property (@(posedge clk) disable iff (!rst_n) !(wr_en && full));

endmodule

// File: tb/tb_inst_fetch_queue.sv
// Directed bench for inst_fetch_queue with a synchronous instruction memory model.
module tb_inst_fetch_queue;

    logic        clk;
    logic        rst_n;
    logic        redirect_valid;
    logic [31:0] redirect_pc;
    logic        imem_rd;
    logic [10:0] imem_addr;
    logic [31:0] imem_rdata;
    logic        deq_ready;
    logic        deq_valid;
    logic [11:0] opcode;
    logic [4:0]  rs, rt, rd, shamt;
    logic [15:0] immediate;
    logic [25:0] address;
    logic [31:0] pc;
    logic [3:0]  count;
    logic        full;
`ifdef IFQ_PREDECODE_EN
    logic        is_branch;
    logic        is_jump;
`endif

    logic [31:0] imem [2048];

    int n_checks = 0;
    int n_pass   = 0;

    inst_fetch_queue dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_rd        (imem_rd),
        .imem_addr      (imem_addr),
        .imem_rdata     (imem_rdata),
        .deq_ready      (deq_ready),
        .deq_valid      (deq_valid),
        .opcode         (opcode),
        .rs             (rs),
        .rt             (rt),
        .rd             (rd),
        .shamt          (shamt),
        .immediate      (immediate),
        .address        (address),
        .pc             (pc),
        .count          (count),
        .full           (full)
`ifdef IFQ_PREDECODE_EN
        ,
        .is_branch      (is_branch),
        .is_jump        (is_jump)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Read data appears one cycle after the request.
    always @(posedge clk) begin
        if (imem_rd) imem_rdata <= imem[imem_addr];
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic next_cycle();
        @(negedge clk);
        #1;
    endtask

    // Hold reset two cycles and release; returns inside cycle 0.
    task automatic restart(input logic rdy);
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        deq_ready      = rdy;
        next_cycle();
        next_cycle();
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        for (int i = 0; i < 2048; i++) imem[i] = {6'h08, 26'(i)};
        imem[0] = 32'h012A4020;
        imem[1] = 32'h8C080004;
        imem[2] = 32'h10000002;
        imem[3] = 32'h08000010;
        imem_rdata     = 32'd0;
        rst_n          = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc    = 32'd0;
        deq_ready      = 1'b0;

        // Reset state
        next_cycle();
        check_eq("rst_deq_valid", 32'(deq_valid), 32'd0);
        check_eq("rst_count", 32'(count), 32'd0);
        check_eq("rst_imem_rd", 32'(imem_rd), 32'd0);
        check_eq("rst_opcode", 32'(opcode), 32'd0);
        check_eq("rst_pc", pc, 32'd0);

        // Streaming with deq_ready=1
        restart(1'b1);
        for (int c = 0; c < 6; c++) begin
            if (c != 0) next_cycle();
            check_eq("s_imem_rd", 32'(imem_rd), 32'd1);
            check_eq("s_imem_addr", 32'(imem_addr), 32'(c));
            check_eq("s_deq_valid", 32'(deq_valid), (c >= 2) ? 32'd1 : 32'd0);
            if (c >= 2) begin
                check_eq("s_pc", pc, 32'(c - 2));
                check_eq("s_count", 32'(count), 32'd1);
            end
            if (c == 2) begin
                check_eq("s_add_opcode", 32'(opcode), 32'h020);
                check_eq("s_add_rs", 32'(rs), 32'd9);
                check_eq("s_add_rt", 32'(rt), 32'd10);
                check_eq("s_add_rd", 32'(rd), 32'd8);
            end
            if (c == 3) begin
                check_eq("s_lw_opcode", 32'(opcode), 32'h8C0);
                check_eq("s_lw_imm", 32'(immediate), 32'd4);
            end
            if (c == 4) begin
                check_eq("s_beq_opcode", 32'(opcode), 32'h100);
`ifdef IFQ_PREDECODE_EN
                check_eq("s_beq_is_branch", 32'(is_branch), 32'd1);
                check_eq("s_beq_is_jump", 32'(is_jump), 32'd0);
`endif
            end
            if (c == 5) begin
                check_eq("s_j_opcode", 32'(opcode), 32'h080);
                check_eq("s_j_address", 32'(address), 32'h10);
`ifdef IFQ_PREDECODE_EN
                check_eq("s_j_is_jump", 32'(is_jump), 32'd1);
                check_eq("s_j_is_branch", 32'(is_branch), 32'd0);
`endif
            end
        end

        // Fill to full with deq_ready=0
        restart(1'b0);
        for (int c = 0; c < 8; c++) begin
            if (c != 0) next_cycle();
            check_eq("f_imem_rd", 32'(imem_rd), 32'd1);
            check_eq("f_imem_addr", 32'(imem_addr), 32'(c));
        end
        next_cycle();
        check_eq("f8_imem_rd", 32'(imem_rd), 32'd0);
        check_eq("f8_count", 32'(count), 32'd7);
        next_cycle();
        check_eq("f9_count", 32'(count), 32'd8);
        check_eq("f9_full", 32'(full), 32'd1);
        check_eq("f9_imem_rd", 32'(imem_rd), 32'd0);
        check_eq("f9_fetch_pc", 32'(imem_addr), 32'd8);
        check_eq("f9_head_pc", pc, 32'd0);
        next_cycle();
        deq_ready = 1'b1;
        #1;
        check_eq("f10_imem_rd_conservative", 32'(imem_rd), 32'd0);
        next_cycle();
        deq_ready = 1'b0;
        check_eq("f11_count", 32'(count), 32'd7);
        check_eq("f11_full", 32'(full), 32'd0);
        check_eq("f11_head_pc", pc, 32'd1);
        check_eq("f11_imem_rd", 32'(imem_rd), 32'd1);
        check_eq("f11_imem_addr", 32'(imem_addr), 32'd8);
        next_cycle();
        check_eq("f12_count", 32'(count), 32'd7);
        check_eq("f12_imem_rd", 32'(imem_rd), 32'd0);
        next_cycle();
        check_eq("f13_count", 32'(count), 32'd8);
        check_eq("f13_full", 32'(full), 32'd1);
        deq_ready = 1'b1;
        for (int k = 1; k <= 8; k++) begin
            check_eq("d_deq_valid", 32'(deq_valid), 32'd1);
            check_eq("d_pc", pc, 32'(k));
            if (k < 8) next_cycle();
        end
        check_eq("d_pc8_opcode", 32'(opcode), 32'h200);
        check_eq("d_pc8_imm", 32'(immediate), 32'd8);

        // Redirect with count=5 and a request in flight
        restart(1'b0);
        repeat (6) next_cycle();
        check_eq("r_count5", 32'(count), 32'd5);
        check_eq("r_pre_imem_rd", 32'(imem_rd), 32'd1);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd100;
        #1;
        check_eq("r_imem_rd_blocked", 32'(imem_rd), 32'd0);
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check_eq("r_count", 32'(count), 32'd0);
        check_eq("r_deq_valid", 32'(deq_valid), 32'd0);
        check_eq("r_imem_addr", 32'(imem_addr), 32'd100);
        check_eq("r_imem_rd", 32'(imem_rd), 32'd1);
        next_cycle();
        check_eq("r1_count", 32'(count), 32'd0);
        next_cycle();
        check_eq("r2_count", 32'(count), 32'd1);
        check_eq("r2_pc", pc, 32'd100);
        check_eq("r2_imm", 32'(immediate), 32'd100);

        // Out-of-range stall after redirect to 2046
        deq_ready      = 1'b1;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd2046;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        check_eq("o_imem_rd0", 32'(imem_rd), 32'd1);
        check_eq("o_addr0", 32'(imem_addr), 32'd2046);
        check_eq("o_count0", 32'(count), 32'd0);
        next_cycle();
        check_eq("o_imem_rd1", 32'(imem_rd), 32'd1);
        check_eq("o_addr1", 32'(imem_addr), 32'd2047);
        next_cycle();
        check_eq("o_imem_rd2", 32'(imem_rd), 32'd0);
        check_eq("o_pc2046", pc, 32'd2046);
        check_eq("o_imm2046", 32'(immediate), 32'd2046);
        next_cycle();
        check_eq("o_pc2047", pc, 32'd2047);
        check_eq("o_imem_rd3", 32'(imem_rd), 32'd0);
        next_cycle();
        check_eq("o_drained", 32'(deq_valid), 32'd0);
        repeat (3) next_cycle();
        check_eq("o_still_empty", 32'(count), 32'd0);
        check_eq("o_still_stalled", 32'(imem_rd), 32'd0);

        // Asynchronous reset mid-stream with count=4
        deq_ready      = 1'b0;
        redirect_valid = 1'b1;
        redirect_pc    = 32'd0;
        next_cycle();
        redirect_valid = 1'b0;
        #1;
        repeat (5) next_cycle();
        check_eq("a_count4", 32'(count), 32'd4);
        rst_n = 1'b0;
        #1;
        check_eq("a_deq_valid", 32'(deq_valid), 32'd0);
        check_eq("a_count", 32'(count), 32'd0);
        check_eq("a_imem_rd", 32'(imem_rd), 32'd0);
        check_eq("a_opcode", 32'(opcode), 32'd0);
        redirect_valid = 1'b1;
        redirect_pc    = 32'd500;
        next_cycle();
        next_cycle();
        redirect_valid = 1'b0;
        rst_n          = 1'b1;
        #1;
        check_eq("a_restart_rd", 32'(imem_rd), 32'd1);
        check_eq("a_restart_addr", 32'(imem_addr), 32'd0);
        next_cycle();
        next_cycle();
        check_eq("a_first_pc", pc, 32'd0);
        check_eq("a_first_opcode", 32'(opcode), 32'h020);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
